// File: rtl/workers_mm_arbiter_if.sv
// ============================================================================
// workers_mm_arbiter_if
// One Avalon-MM link (command + response) with master/slave views.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface workers_mm_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic                debugaccess;
    logic                burstcount;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, writedata, byteenable, read, write, debugaccess, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, writedata, byteenable, read, write, debugaccess, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/workers_mm_arbiter.sv
// ============================================================================
// workers_mm_arbiter
// Two-requester Avalon-MM arbiter with round-robin grant and read-ID routing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module workers_mm_arbiter #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  wire logic              clk_clk,
    input  wire logic              reset_reset_n,
    workers_mm_arbiter_if.slave    s0,
    workers_mm_arbiter_if.slave    s1,
    workers_mm_arbiter_if.master   m,
    output logic                   err_rdv
);

    localparam int c_PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_BE_W  = DATA_W / 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                r_last;

    logic [MAX_PEND-1:0] r_ids;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_err;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_BE_W-1:0]   r_be;
    logic                r_dbg;

    logic                w_req0;
    logic                w_req1;
    logic                w_room;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_push;
    logic                w_push_id;
    logic                w_pop;
    logic                w_nonempty;
    logic                w_head;

    logic [ADDR_W-1:0]   w_m_addr;
    logic [DATA_W-1:0]   w_m_wdata;
    logic [c_BE_W-1:0]   w_m_be;
    logic                w_m_dbg;
    logic                w_m_read;
    logic                w_m_write;
    logic                w_s0_wait;
    logic                w_s1_wait;

    // Burst counts are deliberately ignored; downstream always sees single beats.
    logic w_unused_burst;
    assign w_unused_burst = &{1'b0, s0.burstcount, s1.burstcount};

    assign w_req0     = s0.read | s0.write;
    assign w_req1     = s1.read | s1.write;
    assign w_room     = (r_count < c_CNT_W'(MAX_PEND));
    assign w_elig0    = w_req0 & (s0.write | w_room);
    assign w_elig1    = w_req1 & (s1.write | w_room);
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_ids[r_rd_ptr];

    assign w_push    = ((r_state == c_GNT0) & s0.read & ~s0.write & ~m.waitrequest)
                     | ((r_state == c_GNT1) & s1.read & ~s1.write & ~m.waitrequest);
    assign w_push_id = (r_state == c_GNT1);
    assign w_pop     = m.readdatavalid & w_nonempty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_elig0 && w_elig1) begin
                    w_next = r_last ? c_GNT0 : c_GNT1;
                end else if (w_elig0) begin
                    w_next = c_GNT0;
                end else if (w_elig1) begin
                    w_next = c_GNT1;
                end
            end
            c_GNT0: begin
                if (!w_req0 || !m.waitrequest) begin
                    w_next = c_IDLE;
                end
            end
            c_GNT1: begin
                if (!w_req1 || !m.waitrequest) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // Outside a grant the command fields hold their last driven value.
    always_comb begin
        w_m_addr  = r_addr;
        w_m_wdata = r_wdata;
        w_m_be    = r_be;
        w_m_dbg   = r_dbg;
        w_m_read  = 1'b0;
        w_m_write = 1'b0;
        w_s0_wait = 1'b1;
        w_s1_wait = 1'b1;
        case (r_state)
            c_GNT0: begin
                w_m_addr  = s0.address;
                w_m_wdata = s0.writedata;
                w_m_be    = s0.byteenable;
                w_m_dbg   = s0.debugaccess;
                w_m_write = s0.write;
                w_m_read  = s0.read & ~s0.write;
                w_s0_wait = m.waitrequest;
            end
            c_GNT1: begin
                w_m_addr  = s1.address;
                w_m_wdata = s1.writedata;
                w_m_be    = s1.byteenable;
                w_m_dbg   = s1.debugaccess;
                w_m_write = s1.write;
                w_m_read  = s1.read & ~s1.write;
                w_s1_wait = m.waitrequest;
            end
            default: ;
        endcase
    end

    // Reset value 1 makes s0 the winner of the first tie.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_last <= 1'b1;
        end else if (r_state == c_IDLE) begin
            if (w_next == c_GNT0) begin
                r_last <= 1'b0;
            end else if (w_next == c_GNT1) begin
                r_last <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_dbg   <= 1'b0;
        end else begin
            r_addr  <= w_m_addr;
            r_wdata <= w_m_wdata;
            r_be    <= w_m_be;
            r_dbg   <= w_m_dbg;
        end
    end

    // Read-ID FIFO: one bit per outstanding read naming the requester to route to.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ids    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_ids[r_wr_ptr] <= w_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_err <= 1'b0;
        end else if (m.readdatavalid && !w_nonempty) begin
            r_err <= 1'b1;
        end
    end

    assign m.address     = w_m_addr;
    assign m.writedata   = w_m_wdata;
    assign m.byteenable  = w_m_be;
    assign m.debugaccess = w_m_dbg;
    assign m.read        = w_m_read;
    assign m.write       = w_m_write;
    assign m.burstcount  = 1'b1;

    assign s0.waitrequest   = w_s0_wait;
    assign s1.waitrequest   = w_s1_wait;
    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign s0.readdatavalid = m.readdatavalid & w_nonempty & ~w_head;
    assign s1.readdatavalid = m.readdatavalid & w_nonempty &  w_head;

    assign err_rdv = r_err;

endmodule

`default_nettype wire

// File: tb/tb_workers_mm_arbiter.sv
// ============================================================================
// tb_workers_mm_arbiter
// Directed scenarios plus randomized traffic against a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_workers_mm_arbiter;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_rdv;
    always #5 clk = ~clk;

    workers_mm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s0_if ();
    workers_mm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s1_if ();
    workers_mm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    workers_mm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .s0            (s0_if),
        .s1            (s1_if),
        .m             (m_if),
        .err_rdv       (err_rdv)
    );

    // Requester-side stimulus, indexed by requester number.
    logic          r_in  [2];
    logic          w_in  [2];
    logic [AW-1:0] a_in  [2];
    logic [DW-1:0] d_in  [2];
    logic [BW-1:0] be_in [2];
    logic          dbg_in[2];
    logic          bc_in [2];
    logic          mw;
    logic          mrdv;
    logic [DW-1:0] mrd;

    assign s0_if.read = r_in[0];        assign s1_if.read = r_in[1];
    assign s0_if.write = w_in[0];       assign s1_if.write = w_in[1];
    assign s0_if.address = a_in[0];     assign s1_if.address = a_in[1];
    assign s0_if.writedata = d_in[0];   assign s1_if.writedata = d_in[1];
    assign s0_if.byteenable = be_in[0]; assign s1_if.byteenable = be_in[1];
    assign s0_if.debugaccess = dbg_in[0]; assign s1_if.debugaccess = dbg_in[1];
    assign s0_if.burstcount = bc_in[0]; assign s1_if.burstcount = bc_in[1];
    assign m_if.waitrequest = mw;
    assign m_if.readdatavalid = mrdv;
    assign m_if.readdata = mrd;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), who won last, and
    // a queue of requester numbers for reads still awaiting data.
    int            owner;
    int            last;
    int            q[$];
    bit            err;
    logic [AW-1:0] h_a;
    logic [DW-1:0] h_d;
    logic [BW-1:0] h_be;
    logic          h_dbg;

    task automatic model_reset();
        owner = -1; last = 1; q.delete(); err = 1'b0;
        h_a = '0; h_d = '0; h_be = '0; h_dbg = 1'b0;
    endtask

    task automatic compare_outputs();
        logic e_rd, e_wr, e_dbg;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic [BW-1:0] e_be;
        bit route0, route1;
        if (owner >= 0) begin
            e_wr = w_in[owner]; e_rd = r_in[owner] & ~w_in[owner];
            e_a = a_in[owner]; e_d = d_in[owner]; e_be = be_in[owner]; e_dbg = dbg_in[owner];
        end else begin
            e_wr = 1'b0; e_rd = 1'b0; e_a = h_a; e_d = h_d; e_be = h_be; e_dbg = h_dbg;
        end
        route0 = mrdv && q.size() > 0 && q[0] == 0;
        route1 = mrdv && q.size() > 0 && q[0] == 1;
        chk("m_read", m_if.read, e_rd);
        chk("m_write", m_if.write, e_wr);
        chk("m_address", m_if.address, e_a);
        chk("m_writedata", m_if.writedata, e_d);
        chk("m_byteenable", m_if.byteenable, e_be);
        chk("m_debugaccess", m_if.debugaccess, e_dbg);
        chk("m_burstcount", m_if.burstcount, 1);
        chk("s0_waitrequest", s0_if.waitrequest, (owner == 0) ? mw : 1'b1);
        chk("s1_waitrequest", s1_if.waitrequest, (owner == 1) ? mw : 1'b1);
        chk("s0_readdatavalid", s0_if.readdatavalid, route0);
        chk("s1_readdatavalid", s1_if.readdatavalid, route1);
        chk("s0_readdata", s0_if.readdata, mrd);
        chk("s1_readdata", s1_if.readdata, mrd);
        chk("err_rdv", err_rdv, err);
    endtask

    task automatic model_update();
        int  sz;
        bit  acc_rd, el0, el1;
        sz = q.size();
        acc_rd = (owner >= 0) && r_in[owner] && !w_in[owner] && !mw;
        if (owner >= 0) begin
            h_a = a_in[owner]; h_d = d_in[owner]; h_be = be_in[owner]; h_dbg = dbg_in[owner];
        end
        if (mrdv) begin
            if (sz > 0) void'(q.pop_front());
            else err = 1'b1;
        end
        if (acc_rd) q.push_back(owner);
        if (owner >= 0) begin
            if (!(r_in[owner] || w_in[owner]) || !mw) owner = -1;
        end else begin
            el0 = (r_in[0] || w_in[0]) && (w_in[0] || sz < MP);
            el1 = (r_in[1] || w_in[1]) && (w_in[1] || sz < MP);
            if (el0 && el1) owner = (last == 0) ? 1 : 0;
            else if (el0) owner = 0;
            else if (el1) owner = 1;
            if (owner >= 0) last = owner;
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later.
    task automatic settle();
        #1;
        compare_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        chk("rst_m_read", m_if.read, 0);
        chk("rst_m_write", m_if.write, 0);
        chk("rst_m_address", m_if.address, 0);
        chk("rst_s1_wait", s1_if.waitrequest, 1);
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;
    endtask

    task automatic xfer(input int n, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        r_in[n] = !wr; w_in[n] = wr; a_in[n] = a; d_in[n] = d;
        for (int i = 0; i < 20 && !done; i++) begin
            settle();
            done = (owner == n) && !mw;
            tick();
        end
        r_in[n] = 1'b0; w_in[n] = 1'b0;
        chk("xfer_done", done, 1);
    endtask

    initial begin
        int prev, nwr;
        bit seen;
        for (int n = 0; n < 2; n++) begin
            r_in[n] = 0; w_in[n] = 0; a_in[n] = '0; d_in[n] = '0;
            be_in[n] = '0; dbg_in[n] = 0; bc_in[n] = 0;
        end
        mw = 0; mrdv = 0; mrd = '0;
        model_reset();
        @(negedge clk);
        settle();
        chk("por_s0_wait", s0_if.waitrequest, 1);
        chk("por_m_write", m_if.write, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single s0 write: granted on cycle 2, back to idle on cycle 3.
        w_in[0] = 1; a_in[0] = AW'(32'h100); d_in[0] = 32'hDEADBEEF; be_in[0] = 4'hF;
        settle(); chk("w1_m_write", m_if.write, 0); tick();
        settle();
        chk("w2_m_write", m_if.write, 1);
        chk("w2_s0_wait", s0_if.waitrequest, 0);
        chk("w2_m_addr", m_if.address, 32'h100);
        chk("w2_m_data", m_if.writedata, 32'hDEADBEEF);
        tick();
        w_in[0] = 0;
        settle(); chk("w3_m_write", m_if.write, 0); tick();

        // Both requesting continuously: grants must alternate.
        w_in[0] = 1; w_in[1] = 1; a_in[0] = AW'(0); a_in[1] = AW'(4);
        prev = -1; nwr = 0;
        for (int i = 0; i < 12; i++) begin
            settle();
            if (m_if.write) begin
                if (prev >= 0) chk("alternate", (int'(m_if.address) == prev), 0);
                prev = int'(m_if.address);
                nwr++;
            end
            tick();
        end
        chk("alternate_count", nwr, 6);
        w_in[0] = 0; w_in[1] = 0;

        // Four outstanding s1 reads: fifth stalls, s0 write still proceeds.
        for (int i = 0; i < 4; i++) xfer(1, 1'b0, AW'(32'h200 + i * 4), '0);
        r_in[1] = 1; w_in[0] = 1; seen = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("stall_s1_wait", s1_if.waitrequest, 1);
            chk("stall_no_read", m_if.read, 0);
            if (m_if.write) seen = 1;
            tick();
        end
        chk("stall_s0_granted", seen, 1);
        w_in[0] = 0;
        mrdv = 1; mrd = 32'hA5A5A5A5;
        settle(); chk("stall_ret_s1", s1_if.readdatavalid, 1); tick();
        mrdv = 0; seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            settle();
            if (m_if.read) seen = 1;
            tick();
        end
        chk("fifth_read_granted", seen, 1);
        r_in[1] = 0;
        mrdv = 1;
        for (int i = 0; i < 4; i++) begin
            settle(); chk("drain_s1", s1_if.readdatavalid, 1); tick();
        end
        mrdv = 0;

        // Interleaved reads s0, s1, s0 route back in order.
        xfer(0, 1'b0, AW'(32'h10), '0);
        xfer(1, 1'b0, AW'(32'h20), '0);
        xfer(0, 1'b0, AW'(32'h30), '0);
        mrdv = 1; mrd = 32'h11;
        settle(); chk("ret11_s0", s0_if.readdatavalid, 1); chk("ret11_s1", s1_if.readdatavalid, 0); tick();
        mrd = 32'h22;
        settle(); chk("ret22_s0", s0_if.readdatavalid, 0); chk("ret22_s1", s1_if.readdatavalid, 1); tick();
        mrd = 32'h33;
        settle(); chk("ret33_s0", s0_if.readdatavalid, 1); chk("ret33_s1", s1_if.readdatavalid, 0); tick();
        settle(); chk("pre_spur_err", err_rdv, 0);
        // Spurious return with nothing outstanding.
        chk("spur_s0", s0_if.readdatavalid, 0); chk("spur_s1", s1_if.readdatavalid, 0); tick();
        mrdv = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("spur_err_sticky", err_rdv, 1); tick();
        end
        apply_reset();
        settle(); chk("err_cleared", err_rdv, 0); tick();

        // Reset while s1 holds a grant with two reads outstanding.
        xfer(1, 1'b0, AW'(32'h40), '0);
        xfer(0, 1'b0, AW'(32'h44), '0);
        mw = 1; r_in[1] = 1; a_in[1] = AW'(32'h48);
        for (int i = 0; i < 2; i++) begin settle(); tick(); end
        chk("gnt1_before_reset", owner, 1);
        apply_reset();
        r_in[1] = 0; mw = 0;
        mrdv = 1;
        settle(); chk("late_rdv_s0", s0_if.readdatavalid, 0); chk("late_rdv_s1", s1_if.readdatavalid, 0); tick();
        mrdv = 0;
        settle(); chk("late_rdv_err", err_rdv, 1); tick();
        apply_reset();

        // Randomized traffic.
        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(owner == n && $urandom_range(0, 7) != 0)) begin
                    r_in[n] = ($urandom_range(0, 2) == 0);
                    w_in[n] = ($urandom_range(0, 3) == 0);
                    a_in[n] = AW'($urandom);
                    d_in[n] = $urandom;
                    be_in[n] = BW'($urandom);
                    dbg_in[n] = 1'($urandom);
                    bc_in[n] = 1'($urandom);
                end
            end
            mw = ($urandom_range(0, 2) == 0);
            mrdv = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 80) == 0);
            mrd = $urandom;
            settle();
            tick();
            if (cyc % 300 == 299) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/workers_mm_arbiter.md
WORKERS_MM_ARBITER -- requirements
Module: workers_mm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byteenable width is DATA_W/8.
REQ-003 Parameter MAX_PEND, default 4, maximum outstanding reads tracked (power of 2, 2..16).
REQ-004 clk_clk  in  1  single clock, all logic on rising edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 sN_address/sN_writedata/sN_byteenable/sN_read/sN_write/sN_debugaccess/sN_burstcount  in  ADDR_W/DATA_W/DATA_W/8/1/1/1/1  requester N (N=0,1) Avalon-MM command; s0 is fed by the w_data_out master, s1 by the w_all_out master.
REQ-007 sN_waitrequest  out  1; sN_readdata  out  DATA_W; sN_readdatavalid  out  1  responses to requester N.
REQ-008 m_address/m_writedata/m_byteenable/m_read/m_write/m_debugaccess/m_burstcount  out  ADDR_W/DATA_W/DATA_W/8/1/1/1/1  shared downstream command.
REQ-009 m_waitrequest/m_readdata/m_readdatavalid  in  1/DATA_W/1  downstream responses.
REQ-010 err_rdv  out  1  sticky flag: readdatavalid received with no read outstanding.

Function
REQ-011 FSM states IDLE, GNT0, GNT1, state register only.
REQ-012 "sN request" = sN_read or sN_write; "sN eligible" = request and (sN_write or pending count < MAX_PEND).
REQ-013 IDLE: one eligible -> GNT of that requester next cycle; both eligible -> requester other than last_grant; none -> stay IDLE.
REQ-014 last_grant register updated to N on every IDLE->GNTN transition; reset value 1 (s0 wins first tie).
REQ-015 GNTN: m_* command outputs = sN_* inputs; other state: m_read=0, m_write=0, other m_* outputs hold last value.
REQ-016 GNTN: sN_waitrequest = m_waitrequest; all other cases sN_waitrequest = 1.
REQ-017 GNTN -> IDLE on transfer acceptance (sN request and m_waitrequest=0), or if sN drops request (protocol violation; no transfer issued).
REQ-018 Throughput: one transfer per requester grant; minimum 2 cycles per transfer (arbitration cycle + accept cycle).
REQ-019 m_burstcount forced to 1; sN_burstcount ignored.
REQ-020 sN_read and sN_write both high: write takes priority, read ignored for that transfer.
REQ-021 Read-ID FIFO, depth MAX_PEND: push requester ID on accepted read; pop on m_readdatavalid.
REQ-022 Simultaneous push and pop: count unchanged, both operations performed.
REQ-023 FIFO pointers wrap modulo MAX_PEND; count range 0..MAX_PEND, never exceeds MAX_PEND (enforced by REQ-012).
REQ-024 sN_readdata = m_readdata for both N (broadcast, combinational).
REQ-025 sN_readdatavalid = m_readdatavalid and FIFO non-empty and FIFO head ID = N; combinational, zero added latency.
REQ-026 m_readdatavalid with FIFO empty: no sN_readdatavalid, no pop, err_rdv set to 1 until reset.
REQ-027 Writes never enter FIFO; write completes on acceptance.

Reset
REQ-028 Reset assertion asynchronously forces: state IDLE, last_grant=1, FIFO empty (pointers 0, count 0), err_rdv=0.
REQ-029 In reset: m_read=0, m_write=0, m_address=0, m_writedata=0, m_byteenable=0, m_debugaccess=0, s0/s1_waitrequest=1, s0/s1_readdatavalid=0.
REQ-030 Reset mid-transfer: the in-flight command is dropped and outstanding read IDs are discarded; any late m_readdatavalid after reset sets err_rdv.
REQ-031 Reset deassertion is synchronised externally; first arbitration at the first rising edge with reset_reset_n=1.

Verification
REQ-032 s0 write A=0x100 D=0xDEADBEEF, m_waitrequest=0 -> m_write=1 on cycle 2, s0_waitrequest=0 on the same cycle, FSM back to IDLE on cycle 3.
REQ-033 s0 and s1 request continuously -> grants alternate s0,s1,s0,s1; never two consecutive grants to one requester.
REQ-034 s1 issues 4 reads, downstream holds readdatavalid -> 5th s1 read is stalled (s1_waitrequest=1); an s0 write is still granted; 1 returned readdatavalid lets the 5th read be granted.
REQ-035 Interleaved reads s0,s1,s0 with returns 0x11,0x22,0x33 -> s0_readdatavalid for 0x11 and 0x33, s1_readdatavalid for 0x22 only.
REQ-036 m_readdatavalid=1 with nothing outstanding -> no sN_readdatavalid; err_rdv=1 until reset.
REQ-037 Reset asserted while GNT1 with m_waitrequest=1 and 2 reads pending -> all REQ-029 values immediately; count=0 after release.
